// File: rtl/reset_sequencer.sv
// Reset sequencer: board/soft reset -> stretched network reset -> SoC release once the network reports done.
// Define RESET_TIMEOUT_EN to add the network-done timeout with re-reset retry pulses and a saturating retry count.
`timescale 1ns/1ps
module reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int RETRY_PULSE    = 16
) (
  input  logic       sys_clk_i,
  input  logic       areset_n_i,
  input  logic       soft_rst_i,
  input  logic       net_resetdone_i,
  output logic       net_rst_o,
  output logic       soc_rst_o,
  output logic       soc_rst_n_o,
  output logic       ready_o,
  output logic [2:0] state_o,
  output logic [3:0] retry_cnt_o
);

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    STRETCH  = 3'd1,
    NET_WAIT = 3'd2,
    RETRY    = 3'd3,
    RUN      = 3'd4
  } state_t;

  localparam logic [23:0] STRETCH_LAST = 24'(STRETCH_CYCLES - 1);
`ifdef RESET_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] RETRY_LAST   = 24'(RETRY_PULSE - 1);
`endif

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be 2..4");
  end
  if (STRETCH_CYCLES < 1 || STRETCH_CYCLES > 24'hFFFFFF) begin : g_bad_stretch
    $error("reset_sequencer: STRETCH_CYCLES must be 1..2^24-1");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 24'hFFFFFF) begin : g_bad_timeout
    $error("reset_sequencer: TIMEOUT_CYCLES must be 2..2^24-1");
  end
  if (RETRY_PULSE < 1 || RETRY_PULSE > 24'hFFFFFF) begin : g_bad_retry
    $error("reset_sequencer: RETRY_PULSE must be 1..2^24-1");
  end

  logic [SYNC_STAGES-1:0] rst_pipe;
  logic [SYNC_STAGES-1:0] done_pipe;
  logic                   rst_rel;
  logic                   done_s;
  state_t                 state;
  state_t                 nxt;
  logic [23:0]            cnt;

  assign rst_rel = rst_pipe[SYNC_STAGES-1];
  assign done_s  = done_pipe[SYNC_STAGES-1];

  always_ff @(posedge sys_clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      rst_pipe <= '0;
    end else begin
      rst_pipe <= {rst_pipe[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // A done level seen while the network is still held in reset is stale, so the chain is flushed then.
  always_ff @(posedge sys_clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      done_pipe <= '0;
    end else if (net_rst_o) begin
      done_pipe <= '0;
    end else begin
      done_pipe <= {done_pipe[SYNC_STAGES-2:0], net_resetdone_i};
    end
  end

  always_comb begin
    nxt = state;
    if (soft_rst_i) begin
      nxt = HOLD;
    end else begin
      case (state)
        HOLD:     if (rst_rel) nxt = STRETCH;
        STRETCH:  if (cnt == STRETCH_LAST) nxt = NET_WAIT;
        NET_WAIT: begin
          if (done_s) begin
            nxt = RUN;
          end
`ifdef RESET_TIMEOUT_EN
          else if (cnt == TIMEOUT_LAST) begin
            nxt = RETRY;
          end
`endif
        end
`ifdef RESET_TIMEOUT_EN
        RETRY:    if (cnt == RETRY_LAST) nxt = NET_WAIT;
`endif
        RUN:      if (!done_s) nxt = NET_WAIT;
        default:  nxt = HOLD;
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same edge as state_o.
  always_ff @(posedge sys_clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      state       <= HOLD;
      cnt         <= '0;
      net_rst_o   <= 1'b1;
      soc_rst_o   <= 1'b1;
      soc_rst_n_o <= 1'b0;
      ready_o     <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= (nxt != state || nxt == HOLD || nxt == RUN) ? 24'd0 : cnt + 24'd1;
      net_rst_o   <= (nxt == HOLD) || (nxt == STRETCH) || (nxt == RETRY);
      soc_rst_o   <= (nxt != RUN);
      soc_rst_n_o <= (nxt == RUN);
      ready_o     <= (nxt == RUN);
    end
  end

  assign state_o = state;

`ifdef RESET_TIMEOUT_EN
  logic [3:0] retry_cnt;

  always_ff @(posedge sys_clk_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      retry_cnt <= '0;
    end else if (state == NET_WAIT && nxt == RETRY && retry_cnt != 4'hF) begin
      retry_cnt <= retry_cnt + 4'd1;
    end
  end

  assign retry_cnt_o = retry_cnt;
`else
  assign retry_cnt_o = 4'd0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with a duration-based reference model and randomized stimulus.
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int NS = 2;
  localparam int SC = 8;
  localparam int TC = 32;
  localparam int RP = 4;
`ifdef RESET_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk       = 1'b0;
  logic       areset_n  = 1'b1;
  logic       soft_rst  = 1'b0;
  logic       net_done  = 1'b1;
  logic       net_rst;
  logic       soc_rst;
  logic       soc_rst_n;
  logic       ready;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [10:0] outs;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  localparam logic [10:0] RST_VAL = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};

  reset_sequencer #(
    .SYNC_STAGES(NS), .STRETCH_CYCLES(SC), .TIMEOUT_CYCLES(TC), .RETRY_PULSE(RP)
  ) dut (
    .sys_clk_i(clk), .areset_n_i(areset_n), .soft_rst_i(soft_rst), .net_resetdone_i(net_done),
    .net_rst_o(net_rst), .soc_rst_o(soc_rst), .soc_rst_n_o(soc_rst_n), .ready_o(ready),
    .state_o(state), .retry_cnt_o(retry_cnt)
  );

  assign outs = {state, net_rst, soc_rst, soc_rst_n, ready, retry_cnt};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: state by spec number, cycles spent in it, and recent (done, net_rst) history.
  int m_st    = 0;
  int m_t     = 1;
  int m_retry = 0;
  int m_up    = 0;
  bit q_in[$];
  bit q_net[$];

  function automatic bit m_net_of(input int s);
    return (s == 0) || (s == 1) || (s == 3);
  endfunction

  task automatic m_reset();
    m_st = 0; m_t = 1; m_retry = 0; m_up = 0;
    q_in.delete(); q_net.delete();
  endtask

  task automatic m_step();
    bit released;
    bit ds;
    int nx;
    released = (m_up >= NS);
    ds = (q_in.size() == NS) && q_in[0];
    foreach (q_net[i]) if (q_net[i]) ds = 1'b0;
    nx = m_st;
    if (soft_rst) nx = 0;
    else if (m_st == 0 && released) nx = 1;
    else if (m_st == 1 && m_t == SC) nx = 2;
    else if (m_st == 2 && ds) nx = 4;
    else if (m_st == 2 && TO_EN && m_t == TC) nx = 3;
    else if (m_st == 3 && m_t == RP) nx = 2;
    else if (m_st == 4 && !ds) nx = 2;
    if (m_st == 2 && nx == 3 && m_retry < 15) m_retry++;
    m_t = (nx == m_st) ? m_t + 1 : 1;
    q_in.push_back(net_done);
    q_net.push_back(m_net_of(m_st));
    if (q_in.size() > NS) begin
      void'(q_in.pop_front());
      void'(q_net.pop_front());
    end
    if (m_up < NS) m_up++;
    m_st = nx;
  endtask

  always @(posedge clk or negedge areset_n) begin
    if (!areset_n) m_reset();
    else m_step();
  end

  function automatic logic [10:0] m_outs();
    return {3'(m_st), m_net_of(m_st), (m_st != 4), (m_st == 4), (m_st == 4), 4'(m_retry)};
  endfunction

  always @(negedge clk) chk("cycle_outputs", {21'd0, outs}, {21'd0, m_outs()});

  initial begin
    int waited;
    int w;
    int rise;
    int last_rise;
    int good;

    #1 areset_n = 1'b0;
    #1 chk("areset_async_values", outs, RST_VAL);

    // Release between edges: the next rising edge is cycle 0.
    repeat (3) @(posedge clk);
    #2 areset_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); chk("net_rst_high_c9", net_rst, 1'b1);
    @(negedge clk); chk("net_rst_fall_c10", {state, net_rst}, {3'd2, 1'b0});
    chk("model_pin_netwait", m_st, 2);
    @(negedge clk); @(negedge clk);
    chk("soc_held_c12", {soc_rst, ready}, 2'b10);
    @(negedge clk);
    chk("soc_release_c13", {soc_rst, soc_rst_n, ready, state}, {1'b0, 1'b1, 1'b1, 3'd4});
    chk("model_pin_run", m_st, 4);

    net_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_fall_netwait", {state, soc_rst, net_rst}, {3'd2, 1'b1, 1'b0});
    net_done = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_return_run", {state, ready}, {3'd4, 1'b1});

    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    chk("soft_hold", {state, soc_rst, net_rst}, {3'd0, 1'b1, 1'b1});
    chk("soft_keeps_retry", retry_cnt, 4'd0);
    @(negedge clk); chk("soft_exit_stretch", state, 3'd1);
    repeat (8) @(negedge clk); chk("soft_stretch_len", state, 3'd2);
    repeat (3) @(negedge clk); chk("soft_back_run", ready, 1'b1);

`ifdef RESET_TIMEOUT_EN
    net_done = 1'b0;
    last_rise = 0;
    for (int p = 1; p <= 17; p++) begin
      waited = 0;
      while (net_rst !== 1'b1 && waited < 100) begin @(negedge clk); waited++; end
      chk("retry_pulse_seen", (waited < 100), 1'b1);
      rise = cyc;
      if (p > 1) chk("retry_period", rise - last_rise, 36);
      chk("retry_count", retry_cnt, (p > 15) ? 15 : p);
      last_rise = rise;
      w = 0;
      while (net_rst === 1'b1 && w < 100) begin @(negedge clk); w++; end
      chk("retry_pulse_width", w, RP);
    end
    soft_rst = 1'b1;
    @(negedge clk);
    soft_rst = 1'b0;
    chk("soft_keeps_retry_sat", {state, retry_cnt}, {3'd0, 4'd15});
    waited = 0;
    while (state !== 3'd3 && waited < 200) begin @(negedge clk); waited++; end
    chk("reach_retry", state, 3'd3);
`else
    net_done = 1'b0;
    repeat (3) @(negedge clk);
    good = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (state === 3'd2 && retry_cnt === 4'd0 && net_rst === 1'b0) good++;
    end
    chk("netwait_indefinite", good, 1000);
`endif

    // 1 ns board-reset glitch away from any clock edge.
    #3 areset_n = 1'b0;
    #0.5 chk("glitch_async_values", outs, RST_VAL);
    #0.5 areset_n = 1'b1;
    net_done = 1'b1;
    repeat (3) @(negedge clk); chk("restart_stretch", state, 3'd1);
    repeat (8) @(negedge clk); chk("restart_netwait", {state, net_rst}, {3'd2, 1'b0});
    repeat (3) @(negedge clk); chk("restart_run", ready, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, (i < 1500) ? 29 : 79) == 0) net_done = ~net_done;
      soft_rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 699) == 0) begin
        #1 areset_n = 1'b0;
        #1 areset_n = 1'b1;
      end
    end
    soft_rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: flops in each synchronizer chain, range 2..4.
REQ-002 SHALL have parameter STRETCH_CYCLES, default 1024: hold time after reset release, range 1..2^24-1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1048576: maximum wait for network reset-done, range 2..2^24-1.
REQ-004 SHALL have parameter RETRY_PULSE, default 16: network re-reset pulse length, range 1..2^24-1.
REQ-005 SHALL have port sys_clk_i, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-006 SHALL have port areset_n_i, input, 1 bit: asynchronous, active-low board reset.
REQ-007 SHALL have port soft_rst_i, input, 1 bit: synchronous to sys_clk_i, active-high software/debug reset request.
REQ-008 SHALL have port net_resetdone_i, input, 1 bit: network reset-done; asynchronous to sys_clk_i.
REQ-009 SHALL have port net_rst_o, output, 1 bit: active-high reset to the network block.
REQ-010 SHALL have port soc_rst_o, output, 1 bit: active-high reset to the SoC.
REQ-011 SHALL have port soc_rst_n_o, output, 1 bit: always the inverse of soc_rst_o.
REQ-012 SHALL have port ready_o, output, 1 bit: high only in state RUN.
REQ-013 SHALL have port state_o, output, 3 bits: current state encoding.
REQ-014 SHALL have port retry_cnt_o, output, 4 bits: count of network retries.

Function
REQ-015 SHALL implement the FSM states HOLD=0, STRETCH=1, NET_WAIT=2, RETRY=3 and RUN=4.
REQ-016 SHALL take the release of areset_n_i through a SYNC_STAGES chain (asynchronous assert, synchronous deassert), so HOLD exits SYNC_STAGES cycles after areset_n_i rises.
REQ-017 SHALL pass net_resetdone_i through a SYNC_STAGES chain, giving done_s; all FSM decisions use done_s only.
REQ-018 In HOLD, SHALL move to STRETCH once the synchronized reset is released, clearing the 24-bit cycle counter.
REQ-019 In STRETCH, SHALL count and move to NET_WAIT after exactly STRETCH_CYCLES cycles in STRETCH.
REQ-020 SHALL hold net_rst_o high in HOLD, STRETCH and RETRY, and low in NET_WAIT and RUN.
REQ-021 SHALL hold soc_rst_o high in every state except RUN.
REQ-022 In NET_WAIT, SHALL move to RUN on the cycle after done_s is sampled high; the counter clears on entry to NET_WAIT.
REQ-023 In NET_WAIT with the timeout enabled, after TIMEOUT_CYCLES cycles with done_s low, SHALL move to RETRY and increment retry_cnt_o, saturating at 15.
REQ-024 In RETRY, SHALL stay exactly RETRY_PULSE cycles and then return to NET_WAIT.
REQ-025 In RUN, if done_s falls, SHALL move to NET_WAIT the next cycle, reasserting soc_rst_o; net_rst_o stays low.
REQ-026 A soft_rst_i high in any cycle SHALL force HOLD on the next cycle; HOLD then exits one cycle after soft_rst_i is low, the synchronizer being already released.
REQ-027 If soft_rst_i and done_s are high in the same cycle, soft_rst_i SHALL take priority.
REQ-028 retry_cnt_o SHALL clear only on areset_n_i; soft_rst_i SHALL NOT clear it.
REQ-029 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-030 areset_n_i low SHALL, immediately and without a clock, set state HOLD, net_rst_o=1, soc_rst_o=1, soc_rst_n_o=0, ready_o=0, state_o=0, retry_cnt_o=0, counter=0 and all synchronizer flops to the asserted value.
REQ-031 areset_n_i asserted mid-operation (any state, including RETRY) SHALL give the REQ-030 values asynchronously, and the full sequence SHALL restart on release.

Configuration
REQ-032 SHALL define macro RESET_TIMEOUT_EN: when defined, REQ-023 and REQ-024 are active; when undefined, NET_WAIT waits indefinitely for done_s, RETRY is unreachable, retry_cnt_o is tied to 0 and the TIMEOUT_CYCLES and RETRY_PULSE logic is absent.

Verification (SYNC_STAGES=2, STRETCH_CYCLES=8, TIMEOUT_CYCLES=32, RETRY_PULSE=4)
REQ-033 Scenario: areset_n_i rises at cycle 0 with net_resetdone_i held high -> net_rst_o falls at cycle 10, soc_rst_o falls and ready_o rises at cycle 13.
REQ-034 Scenario (RESET_TIMEOUT_EN defined): net_resetdone_i held low -> net_rst_o pulses high for 4 cycles every 36 cycles, and retry_cnt_o goes 1, 2, 3 ... and holds at 15.
REQ-035 Scenario: in RUN, 1-cycle soft_rst_i pulse -> next cycle state_o=0 and soc_rst_o=1, then the STRETCH sequence repeats, and retry_cnt_o is unchanged.
REQ-036 Scenario: in RUN, net_resetdone_i falls -> state_o=2 and soc_rst_o=1 within 3 cycles, and net_rst_o stays 0.
REQ-037 Scenario: areset_n_i pulsed low for 1 ns during RETRY, off any clock edge -> all outputs take their REQ-030 values asynchronously.
REQ-038 Scenario (RESET_TIMEOUT_EN undefined): net_resetdone_i held low for 1000 cycles -> state_o=2 throughout and retry_cnt_o=0.
